// File: rtl/bs_gnrtr_n_rbtr.sv
// Shared-bus generator and round-robin arbiter: pops one packet from a
// pending source, then pushes it to the addressed device(s).
// Ports:
//    clk, reset (async, active-high)
//    pndng  - per-device source FIFO non-empty
//    D_pop  - per-device head-of-FIFO packet
//    pop    - one-cycle pop strobe to the winning source
//    push   - one-cycle write strobe to each destination
//    D_push - bus data, same packet on every entry
module bs_gnrtr_n_rbtr #(
   parameter int             bits      = 1,
   parameter int             drvrs     = 4,
   parameter int             pckg_sz   = 16,
   parameter logic [7:0]     broadcast = 8'hFF
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic [bits-1:0][drvrs-1:0]               pndng,
   input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_pop,
   output logic [bits-1:0][drvrs-1:0]               pop,
   output logic [bits-1:0][drvrs-1:0]               push,
   output logic [bits-1:0][drvrs-1:0][pckg_sz-1:0]  D_push
);

   localparam int IW = (drvrs > 1) ? $clog2(drvrs) : 1;

   typedef enum logic [1:0] {
      IDLE,
      POP,
      PUSH
   } state_t;

   state_t             state;
   logic [IW-1:0]      last;
   logic [IW-1:0]      win;
   logic [IW-1:0]      nxt;
   logic [pckg_sz-1:0] pkt;
   logic [7:0]         dest;
   logic [drvrs-1:0]   mask;

   // Round-robin: first pending device at or after last+1, wrapping.
   always_comb begin
      int   j;
      logic found;
      j     = 0;
      found = 1'b0;
      nxt   = '0;
      for (int i = 1; i <= drvrs; i++) begin
         j = (int'(last) + i) % drvrs;
         if (!found && pndng[0][j]) begin
            found = 1'b1;
            nxt   = IW'(j);
         end
      end
   end

   // Destination decode on the winner's head packet. Broadcast skips the
   // source; an ID with no matching device yields an empty mask (drop).
   always_comb begin
      dest = D_pop[0][win][pckg_sz-1 -: 8];
      mask = '0;
      for (int k = 0; k < drvrs; k++) begin
         if (dest == broadcast)
            mask[k] = (int'(win) != k);
         else
            mask[k] = (int'(dest) == k);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         pop   <= '0;
         push  <= '0;
         pkt   <= '0;
         win   <= '0;
         last  <= IW'(drvrs - 1);
      end else begin
         unique case (state)
            IDLE: begin
               push <= '0;
               pop  <= '0;
               if (|pndng[0]) begin
                  pop[0][nxt] <= 1'b1;
                  win         <= nxt;
                  state       <= POP;
               end
            end
            POP: begin
               pop     <= '0;
               pkt     <= D_pop[0][win];
               last    <= win;
               push    <= '0;
               push[0] <= mask;
               state   <= PUSH;
            end
            PUSH: begin
               push  <= '0;
               pop   <= '0;
               state <= IDLE;
            end
            default: begin
               pop   <= '0;
               push  <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Bus data mirrors the packet register, so it holds between pushes.
   always_comb begin
      D_push = '0;
      for (int b = 0; b < bits; b++)
         for (int k = 0; k < drvrs; k++)
            D_push[b][k] = pkt;
   end

endmodule

// File: tb/tb_bs_gnrtr_n_rbtr.sv
// Directed bench for bs_gnrtr_n_rbtr: unicast, broadcast, round-robin,
// invalid ID and mid-transaction reset.
module tb_bs_gnrtr_n_rbtr;

   logic                   clk;
   logic                   reset;
   logic [0:0][3:0]        pndng;
   logic [0:0][3:0][15:0]  d_pop;
   logic [0:0][3:0]        pop;
   logic [0:0][3:0]        push;
   logic [0:0][3:0][15:0]  d_push;

   int checks = 0;
   int errors = 0;

   bs_gnrtr_n_rbtr dut (
      .clk    (clk),
      .reset  (reset),
      .pndng  (pndng),
      .D_pop  (d_pop),
      .pop    (pop),
      .push   (push),
      .D_push (d_push)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic chk_bus(input string tag, input logic [15:0] exp);
      for (int k = 0; k < 4; k++)
         chk(tag, 64'(d_push[0][k]), 64'(exp));
   endtask

   initial begin
      logic [15:0] rr_pkt;
      reset = 1'b1;
      pndng = '0;
      d_pop = '0;
      #2;
      chk("rst_pop", 64'(pop), 64'h0);
      chk("rst_push", 64'(push), 64'h0);
      chk_bus("rst_dpush", 16'h0000);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk("idle_pop", 64'(pop), 64'h0);

      // Unicast 1 -> 2
      pndng[0]    = 4'b0010;
      d_pop[0][1] = 16'h02AB;
      tick();
      chk("uc_pop", 64'(pop), 64'h2);
      chk("uc_nopush", 64'(push), 64'h0);
      pndng[0] = 4'b0000;
      tick();
      chk("uc_pop_end", 64'(pop), 64'h0);
      chk("uc_push", 64'(push), 64'h4);
      chk_bus("uc_data", 16'h02AB);
      d_pop[0][1] = 16'h0000;
      tick();
      chk("uc_push_end", 64'(push), 64'h0);
      chk_bus("uc_hold", 16'h02AB);

      // Broadcast from 0
      pndng[0]    = 4'b0001;
      d_pop[0][0] = 16'hFF55;
      tick();
      chk("bc_pop", 64'(pop), 64'h1);
      pndng[0] = 4'b0000;
      tick();
      chk("bc_push", 64'(push), 64'hE);
      chk_bus("bc_data", 16'hFF55);
      tick();
      chk("bc_push_end", 64'(push), 64'h0);

      // Round-robin after a fresh reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++)
         d_pop[0][k] = 16'h0010 + 16'(k);
      pndng[0] = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         tick();
         chk("rr_pop", 64'(pop), 64'(1 << (n % 4)));
         chk("rr_nopush", 64'(push), 64'h0);
         tick();
         chk("rr_push", 64'(push), 64'h1);
         chk("rr_popoff", 64'(pop), 64'h0);
         rr_pkt = 16'h0010 + 16'(n % 4);
         chk("rr_data", 64'(d_push[0][2]), 64'(rr_pkt));
         tick();
         chk("rr_idle", 64'(push | pop), 64'h0);
      end

      // Invalid ID from 3 (last grant is 0)
      pndng[0]    = 4'b1000;
      d_pop[0][3] = 16'h0711;
      tick();
      chk("inv_pop", 64'(pop), 64'h8);
      tick();
      chk("inv_push", 64'(push), 64'h0);
      chk_bus("inv_data", 16'h0711);
      tick();
      chk("inv_idle", 64'(push | pop), 64'h0);
      tick();
      chk("inv_rearb", 64'(pop), 64'h8);
      pndng[0] = 4'b0000;
      tick();
      chk("inv_push2", 64'(push), 64'h0);
      tick();

      // Reset during POP
      pndng[0]    = 4'b0100;
      d_pop[0][2] = 16'h0122;
      tick();
      chk("mr_pop", 64'(pop), 64'h4);
      reset = 1'b1;
      #1;
      chk("mr_pop_kill", 64'(pop), 64'h0);
      chk_bus("mr_dpush", 16'h0000);
      tick();
      chk("mr_nopush", 64'(push), 64'h0);
      pndng[0]    = 4'b0101;
      d_pop[0][0] = 16'h0133;
      reset = 1'b0;
      tick();
      chk("mr_grant0", 64'(pop), 64'h1);
      chk("mr_nopush2", 64'(push), 64'h0);
      pndng[0] = 4'b0100;
      tick();
      chk("mr_push", 64'(push), 64'h2);
      chk_bus("mr_data", 16'h0133);
      tick();
      tick();
      chk("mr_next", 64'(pop), 64'h4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
